// File: rtl/trinita_io_pkg.sv
// Shared constants for the APB I/O controller: decode widths and register word indices.
package trinita_io_pkg;

  localparam int unsigned DEC_W     = 6;
  localparam int unsigned DUTY_W    = 8;
  localparam int unsigned PRESC_W   = 16;
  localparam int unsigned DUTY_BASE = 8;

  // Word indices (PADDR[7:2]) of the register map.
  typedef enum logic [DEC_W-1:0] {
    REG_OUT_DATA  = 6'h00,
    REG_IN_DATA   = 6'h01,
    REG_EDGE_STAT = 6'h02,
    REG_IRQ_EN    = 6'h03,
    REG_EDGE_MODE = 6'h04,
    REG_PWM_EN    = 6'h05,
    REG_PRESC     = 6'h06,
    REG_DUTY0     = 6'h08
  } reg_idx_e;

endpackage

// File: rtl/io_debounce.sv
// One input channel: 2-FF synchroniser, stability counter, debounced level and edge pulses.
module io_debounce
  import trinita_io_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 50000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_in,
  output logic o_state,
  output logic o_rise,
  output logic o_fall
);

  localparam int unsigned    CW   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0]  LAST = CW'(DEB_CYCLES - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_state;
  logic [CW-1:0] r_cnt;
  logic          w_diff;
  logic          w_flip;

  assign w_diff = r_s2 ^ r_state;
  assign w_flip = w_diff && (r_cnt == LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_state <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_s1 <= i_in;
      r_s2 <= r_s1;
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_flip) begin
        r_cnt   <= '0;
        r_state <= ~r_state;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Pulses are combinational so edge capture lands on the same edge as the level flip.
  assign o_state = r_state;
  assign o_rise  = w_flip & ~r_state;
  assign o_fall  = w_flip & r_state;

endmodule

// File: rtl/apb_io_ctrl.sv
// APB3 I/O controller: LED outputs with per-channel PWM dimming, debounced inputs with edge IRQ.
module apb_io_ctrl
  import trinita_io_pkg::*;
#(
  parameter int unsigned N_OUT      = 8,
  parameter int unsigned N_IN       = 1,
  parameter int unsigned DEB_CYCLES = 50000
) (
  input  logic              io_systemClk,
  input  logic              io_asyncResetn,
  input  logic [15:0]       io_apbSlave_0_PADDR,
  input  logic              io_apbSlave_0_PSEL,
  input  logic              io_apbSlave_0_PENABLE,
  input  logic              io_apbSlave_0_PWRITE,
  input  logic [31:0]       io_apbSlave_0_PWDATA,
  output logic [31:0]       io_apbSlave_0_PRDATA,
  output logic              io_apbSlave_0_PREADY,
  output logic              io_apbSlave_0_PSLVERROR,
  input  logic [N_IN-1:0]   i_in,
  output logic [N_OUT-1:0]  o_out,
  output logic              o_irq
);

  logic [N_OUT-1:0]   r_out_data;
  logic [N_OUT-1:0]   r_pwm_en;
  logic [N_IN-1:0]    r_edge_stat;
  logic [N_IN-1:0]    r_irq_en;
  logic [N_IN-1:0]    r_edge_mode;
  logic [PRESC_W-1:0] r_presc;
  logic [PRESC_W-1:0] r_pcnt;
  logic [DUTY_W-1:0]  r_phase;
  logic [DUTY_W-1:0]  r_duty [N_OUT];
  logic [N_OUT-1:0]   r_out;
  logic               r_irq;

  logic               w_acc;
  logic               w_wr;
  logic [DEC_W-1:0]   w_idx;
  logic               w_mapped;
  logic               w_tick;
  logic [N_IN-1:0]    w_in_db;
  logic [N_IN-1:0]    w_rise;
  logic [N_IN-1:0]    w_fall;
  logic [N_IN-1:0]    w_clr;
  logic [N_OUT-1:0]   w_out_next;
  logic [31:0]        w_rdata;
  logic               w_unused;

  assign w_acc    = io_apbSlave_0_PSEL & io_apbSlave_0_PENABLE;
  assign w_wr     = w_acc & io_apbSlave_0_PWRITE;
  assign w_idx    = io_apbSlave_0_PADDR[7:2];
  assign w_mapped = (w_idx <= REG_PRESC) ||
                    ((w_idx >= REG_DUTY0) && (w_idx < DEC_W'(DUTY_BASE + N_OUT)));
  assign w_tick   = (r_pcnt == r_presc);
  assign w_clr    = (w_wr && w_idx == REG_EDGE_STAT) ? io_apbSlave_0_PWDATA[N_IN-1:0] : '0;
  assign w_unused = ^{io_apbSlave_0_PADDR[15:8], io_apbSlave_0_PADDR[1:0], io_apbSlave_0_PWDATA};

  for (genvar g = 0; g < N_IN; g++) begin : g_deb
    io_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .i_clk   (io_systemClk),
      .i_rst_n (io_asyncResetn),
      .i_in    (i_in[g]),
      .o_state (w_in_db[g]),
      .o_rise  (w_rise[g]),
      .o_fall  (w_fall[g])
    );
  end

  always_comb begin
    w_out_next = '0;
    for (int unsigned i = 0; i < N_OUT; i++) begin
      w_out_next[i] = r_out_data[i] & (r_pwm_en[i] ? (r_phase < r_duty[i]) : 1'b1);
    end
  end

  always_comb begin
    w_rdata = '0;
    if (w_acc) begin
      case (w_idx)
        REG_OUT_DATA:  w_rdata[N_OUT-1:0]   = r_out_data;
        REG_IN_DATA:   w_rdata[N_IN-1:0]    = w_in_db;
        REG_EDGE_STAT: w_rdata[N_IN-1:0]    = r_edge_stat;
        REG_IRQ_EN:    w_rdata[N_IN-1:0]    = r_irq_en;
        REG_EDGE_MODE: w_rdata[N_IN-1:0]    = r_edge_mode;
        REG_PWM_EN:    w_rdata[N_OUT-1:0]   = r_pwm_en;
        REG_PRESC:     w_rdata[PRESC_W-1:0] = r_presc;
        default: begin
          for (int unsigned i = 0; i < N_OUT; i++) begin
            if (w_idx == DEC_W'(DUTY_BASE + i)) w_rdata[DUTY_W-1:0] = r_duty[i];
          end
        end
      endcase
    end
  end

  always_ff @(posedge io_systemClk or negedge io_asyncResetn) begin
    if (!io_asyncResetn) begin
      r_out_data  <= '0;
      r_pwm_en    <= '0;
      r_edge_stat <= '0;
      r_irq_en    <= '0;
      r_edge_mode <= '0;
      r_presc     <= '0;
      r_pcnt      <= '0;
      r_phase     <= '0;
      r_out       <= '0;
      r_irq       <= 1'b0;
      for (int unsigned i = 0; i < N_OUT; i++) r_duty[i] <= '0;
    end else begin
      if (w_wr) begin
        case (w_idx)
          REG_OUT_DATA:  r_out_data  <= io_apbSlave_0_PWDATA[N_OUT-1:0];
          REG_IRQ_EN:    r_irq_en    <= io_apbSlave_0_PWDATA[N_IN-1:0];
          REG_EDGE_MODE: r_edge_mode <= io_apbSlave_0_PWDATA[N_IN-1:0];
          REG_PWM_EN:    r_pwm_en    <= io_apbSlave_0_PWDATA[N_OUT-1:0];
          REG_PRESC:     r_presc     <= io_apbSlave_0_PWDATA[PRESC_W-1:0];
          default: ;
        endcase
      end
      for (int unsigned i = 0; i < N_OUT; i++) begin
        if (w_wr && w_idx == DEC_W'(DUTY_BASE + i)) r_duty[i] <= io_apbSlave_0_PWDATA[DUTY_W-1:0];
      end
      // New edges are OR-ed after the clear so a same-cycle set survives W1C.
      r_edge_stat <= (r_edge_stat & ~w_clr) | w_rise | (w_fall & r_edge_mode);
      if (w_wr && w_idx == REG_PRESC) r_pcnt <= '0;
      else if (w_tick)                r_pcnt <= '0;
      else                            r_pcnt <= r_pcnt + 1'b1;
      if (w_tick) r_phase <= r_phase + 1'b1;
      r_out <= w_out_next;
      r_irq <= |(r_edge_stat & r_irq_en);
    end
  end

  assign io_apbSlave_0_PRDATA    = w_rdata;
  assign io_apbSlave_0_PREADY    = 1'b1;
  assign io_apbSlave_0_PSLVERROR = w_acc & ~w_mapped;
  assign o_out                   = r_out;
  assign o_irq                   = r_irq;

endmodule

// File: tb/tb_apb_io_ctrl.sv
// Scoreboard bench for apb_io_ctrl: register map, PWM, debounce, edge capture and IRQ.
module tb_apb_io_ctrl;

  localparam int unsigned N_OUT = 8;
  localparam int unsigned N_IN  = 2;
  localparam int unsigned DEB   = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [15:0]       paddr = '0;
  logic              psel = 1'b0;
  logic              penable = 1'b0;
  logic              pwrite = 1'b0;
  logic [31:0]       pwdata = '0;
  logic [31:0]       prdata;
  logic              pready;
  logic              pslverr;
  logic [N_IN-1:0]   i_in = '0;
  logic [N_OUT-1:0]  o_out;
  logic              o_irq;

  apb_io_ctrl #(.N_OUT(N_OUT), .N_IN(N_IN), .DEB_CYCLES(DEB)) dut (
    .io_systemClk            (clk),
    .io_asyncResetn          (rst_n),
    .io_apbSlave_0_PADDR     (paddr),
    .io_apbSlave_0_PSEL      (psel),
    .io_apbSlave_0_PENABLE   (penable),
    .io_apbSlave_0_PWRITE    (pwrite),
    .io_apbSlave_0_PWDATA    (pwdata),
    .io_apbSlave_0_PRDATA    (prdata),
    .io_apbSlave_0_PREADY    (pready),
    .io_apbSlave_0_PSLVERROR (pslverr),
    .i_in                    (i_in),
    .o_out                   (o_out),
    .o_irq                   (o_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] got);
    exp_t e;
    if (sb.size() == 0) begin
      check_eq("sb_underflow", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check_eq(e.tag, got, e.val);
    end
  endtask

  task automatic expect_now(input string tag, input logic [31:0] got, input logic [31:0] exp);
    sb_push(tag, exp);
    sb_pop(got);
  endtask

  task automatic apb_rd(input logic [15:0] a, input logic [31:0] exp_d, input logic exp_e,
                        input string tag);
    sb_push({tag, ".data"}, exp_d);
    sb_push({tag, ".err"}, {31'b0, exp_e});
    @(posedge clk); #1;
    paddr = a; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    #3;
    sb_pop(prdata);
    sb_pop({31'b0, pslverr});
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  // Returns 1 time unit after the edge on which the write commits.
  task automatic apb_wr(input logic [15:0] a, input logic [31:0] d, input logic exp_e,
                        input string tag);
    sb_push({tag, ".err"}, {31'b0, exp_e});
    @(posedge clk); #1;
    paddr = a; pwdata = d; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    #3;
    sb_pop({31'b0, pslverr});
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic count_high(input int cycles, output int n);
    n = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk); #1;
      if (o_out[0] === 1'b1) n++;
    end
  endtask

  task automatic high_run(output int run);
    int w;
    w   = 0;
    run = 0;
    while (o_out[0] !== 1'b0 && w < 3000) begin @(posedge clk); #1; w++; end
    while (o_out[0] !== 1'b1 && w < 3000) begin @(posedge clk); #1; w++; end
    while (o_out[0] === 1'b1 && run < 3000) begin run++; @(posedge clk); #1; end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    int  changes;
    logic ref_bit;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    expect_now("rst.o_out", {24'b0, o_out}, 32'h0);
    expect_now("rst.o_irq", {31'b0, o_irq}, 32'h0);
    expect_now("rst.prdata_idle", prdata, 32'h0);
    expect_now("rst.pready", {31'b0, pready}, 32'h1);
    for (int a = 0; a <= 'h18; a += 4) apb_rd(16'(a), 32'h0, 1'b0, "rst.reg");
    apb_rd(16'h001C, 32'h0, 1'b1, "unmapped_1c");
    for (int a = 'h20; a <= 'h3C; a += 4) apb_rd(16'(a), 32'h0, 1'b0, "rst.duty");
    apb_rd(16'h0040, 32'h0, 1'b1, "duty_slot8");

    // OUT_DATA with junk in upper bits; o_out follows one cycle after the access phase.
    apb_wr(16'h0000, 32'hFFFF_FFA5, 1'b0, "wr_out");
    expect_now("out.same_cycle", {24'b0, o_out}, 32'h0);
    wait_cycles(1);
    expect_now("out.next_cycle", {24'b0, o_out}, 32'hA5);
    apb_rd(16'h0000, 32'h0000_00A5, 1'b0, "rd_out");

    apb_wr(16'h0040, 32'h0000_0055, 1'b1, "wr_slot8");
    apb_wr(16'h001C, 32'h0000_00FF, 1'b1, "wr_1c");
    apb_rd(16'h0018, 32'h0, 1'b0, "presc_after_unmapped");
    apb_wr(16'h0018, 32'h0001_0000, 1'b0, "wr_presc_hi");
    apb_rd(16'h0018, 32'h0, 1'b0, "presc_upper_ignored");

    apb_wr(16'h0014, 32'h1, 1'b0, "wr_pwm_en");
    apb_wr(16'h0020, 32'd64, 1'b0, "wr_duty64");
    apb_rd(16'h0020, 32'd64, 1'b0, "rd_duty0");
    wait_cycles(3);
    count_high(256, n);
    expect_now("pwm.duty64_cnt", 32'(n), 32'd64);
    expect_now("pwm.other_bits", {24'b0, o_out[7:1], 1'b0}, 32'hA4);
    high_run(n);
    expect_now("pwm.duty64_run", 32'(n), 32'd64);

    apb_wr(16'h0020, 32'd0, 1'b0, "wr_duty0");
    wait_cycles(3);
    count_high(256, n);
    expect_now("pwm.duty0_cnt", 32'(n), 32'd0);
    apb_wr(16'h0020, 32'd255, 1'b0, "wr_duty255");
    wait_cycles(3);
    count_high(256, n);
    expect_now("pwm.duty255_cnt", 32'(n), 32'd255);

    apb_wr(16'h0020, 32'd64, 1'b0, "wr_duty64b");
    apb_wr(16'h0018, 32'd3, 1'b0, "wr_presc3");
    high_run(n);
    expect_now("pwm.presc3_run", 32'(n), 32'd256);

    // Rewriting PRESC every 3 cycles keeps the prescaler from ever reaching 3.
    apb_wr(16'h0020, 32'd128, 1'b0, "wr_duty128");
    changes = 0;
    ref_bit = 1'b0;
    for (int k = 0; k < 400; k++) begin
      apb_wr(16'h0018, 32'd3, 1'b0, "presc_rw");
      if (k == 2) ref_bit = o_out[0];
      else if (k > 2 && o_out[0] !== ref_bit) changes++;
    end
    expect_now("presc.restart_frozen", 32'(changes), 32'd0);
    apb_wr(16'h0018, 32'd0, 1'b0, "wr_presc0");
    apb_wr(16'h0014, 32'h0, 1'b0, "wr_pwm_off");

    apb_wr(16'h000C, 32'h1, 1'b0, "wr_irq_en");

    @(posedge clk); #1 i_in[0] = 1'b1;
    repeat (5) @(posedge clk);
    #1 i_in[0] = 1'b0;
    wait_cycles(20);
    apb_rd(16'h0004, 32'h0, 1'b0, "glitch.in_data");
    apb_rd(16'h0008, 32'h0, 1'b0, "glitch.edge_stat");
    expect_now("glitch.irq", {31'b0, o_irq}, 32'h0);

    @(posedge clk); #1 i_in[0] = 1'b1;
    wait_cycles(10);
    expect_now("rise.irq_not_yet", {31'b0, o_irq}, 32'h0);
    wait_cycles(1);
    expect_now("rise.irq_set", {31'b0, o_irq}, 32'h1);
    apb_rd(16'h0004, 32'h1, 1'b0, "rise.in_data");
    apb_rd(16'h0008, 32'h1, 1'b0, "rise.edge_stat");

    apb_wr(16'h0008, 32'h1, 1'b0, "w1c_a");
    wait_cycles(1);
    expect_now("w1c_a.irq", {31'b0, o_irq}, 32'h0);
    apb_rd(16'h0008, 32'h0, 1'b0, "w1c_a.stat");

    i_in[0] = 1'b0;
    wait_cycles(20);
    apb_rd(16'h0004, 32'h0, 1'b0, "fall_m0.in_data");
    apb_rd(16'h0008, 32'h0, 1'b0, "fall_m0.stat");
    expect_now("fall_m0.irq", {31'b0, o_irq}, 32'h0);

    apb_wr(16'h0010, 32'h1, 1'b0, "wr_mode");
    i_in[0] = 1'b1;
    wait_cycles(20);
    apb_wr(16'h0008, 32'h1, 1'b0, "w1c_b");
    wait_cycles(2);
    apb_rd(16'h0008, 32'h0, 1'b0, "w1c_b.stat");
    i_in[0] = 1'b0;
    wait_cycles(20);
    apb_rd(16'h0004, 32'h0, 1'b0, "fall_m1.in_data");
    apb_rd(16'h0008, 32'h1, 1'b0, "fall_m1.stat");
    expect_now("fall_m1.irq", {31'b0, o_irq}, 32'h1);

    // Debounced rise lands on the same edge as the W1C commit.
    @(posedge clk); #1 i_in[0] = 1'b1;
    wait_cycles(7);
    apb_wr(16'h0008, 32'h1, 1'b0, "w1c_coll");
    expect_now("coll.irq0", {31'b0, o_irq}, 32'h1);
    wait_cycles(1);
    expect_now("coll.irq1", {31'b0, o_irq}, 32'h1);
    apb_rd(16'h0008, 32'h1, 1'b0, "coll.stat");
    apb_rd(16'h0004, 32'h1, 1'b0, "coll.in_data");
    apb_wr(16'h0008, 32'h1, 1'b0, "w1c_late");
    wait_cycles(1);
    expect_now("late.irq", {31'b0, o_irq}, 32'h0);
    apb_rd(16'h0008, 32'h0, 1'b0, "late.stat");

    i_in[0] = 1'b0;
    wait_cycles(20);
    expect_now("irqen.before", {31'b0, o_irq}, 32'h1);
    apb_wr(16'h000C, 32'h0, 1'b0, "wr_irq_dis");
    expect_now("irqen.same_cycle", {31'b0, o_irq}, 32'h1);
    wait_cycles(1);
    expect_now("irqen.off", {31'b0, o_irq}, 32'h0);
    apb_rd(16'h0008, 32'h1, 1'b0, "irqen.stat_kept");

    expect_now("arst.out_before", {24'b0, o_out}, 32'hA5);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    expect_now("arst.o_out", {24'b0, o_out}, 32'h0);
    expect_now("arst.o_irq", {31'b0, o_irq}, 32'h0);
    wait_cycles(2);
    rst_n = 1'b1;
    apb_rd(16'h0000, 32'h0, 1'b0, "arst.out_data");
    apb_rd(16'h0008, 32'h0, 1'b0, "arst.edge_stat");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
